noc_packet_arbiter: RTL and testbench

- Shares one NoC injection channel of a tile between INPUTS local packet sources: DMA, message-passing endpoint, debug bridge.
- Round-robin arbitration, locked per packet, so a granted source keeps the channel until its last flit.
- One registered output stage drives the noc_out_flit/last/valid of one channel of riscv_tile towards noc_mesh3d.

---
 rtl/riscv_noc_arb_pkg.sv | 18 +
 rtl/noc_rr_select.sv | 40 ++++
 rtl/noc_packet_arbiter.sv | 94 +++++++++
 tb/tb_noc_packet_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_noc_arb_pkg.sv
// Shared types and helpers for the NoC injection arbiters.
//   arb_state_t : packet-lock FSM state (idle / packet in flight)
//   onehot()    : index -> one-hot vector, MAX_INPUTS wide; callers slice
package riscv_noc_arb_pkg;

  localparam int MAX_INPUTS = 16;
  localparam int MAX_IDXW   = 4;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  function automatic logic [MAX_INPUTS-1:0] onehot(input logic [MAX_IDXW-1:0] idx);
    logic [MAX_INPUTS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/noc_rr_select.sv
// Rotate-priority encoder: returns the first asserted request found when
// scanning ptr, ptr+1, ... modulo N.
//   req   : request vector
//   ptr   : index with highest priority
//   idx   : winning index (0 when nothing found)
//   found : at least one request asserted
module noc_rr_select #(
  parameter int N    = 3,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] idx,
  output logic            found
);

  // One extra bit so ptr+k cannot overflow before the modulo fold.
  localparam logic [IDXW:0] NW = (IDXW+1)'(N);

  logic [IDXW:0]   pos;
  logic [IDXW-1:0] pos_w;

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    pos_w = '0;
    for (int k = N-1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (IDXW+1)'(k);
      if (pos >= NW) pos = pos - NW;
      pos_w = pos[IDXW-1:0];
      if (req[pos_w]) begin
        idx   = pos_w;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_packet_arbiter.sv
// Packet-locked round-robin arbiter sharing one NoC injection channel
// between INPUTS local sources, with one registered output stage.
//   clk, rst                        : clock, async active-low reset
//   in_flit/in_last/in_valid        : per-source flit streams
//   in_ready                        : per-source accept (granted source only)
//   out_flit/out_last/out_valid     : registered flit towards the NoC
//   out_ready                       : NoC accepts the output flit
//   grant                           : one-hot owner, 0 when idle
//   busy                            : a packet is in progress
// INPUTS must be in 2..16.
module noc_packet_arbiter
  import riscv_noc_arb_pkg::*;
#(
  parameter int FLIT_WIDTH = 32,
  parameter int INPUTS     = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [INPUTS-1:0][FLIT_WIDTH-1:0] in_flit,
  input  logic [INPUTS-1:0]                in_last,
  input  logic [INPUTS-1:0]                in_valid,
  output logic [INPUTS-1:0]                in_ready,
  output logic [FLIT_WIDTH-1:0]            out_flit,
  output logic                             out_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [INPUTS-1:0]                grant,
  output logic                             busy
);

  localparam int IDXW = $clog2(INPUTS);

  arb_state_t            state;
  logic [IDXW-1:0]       rr_ptr;
  logic [IDXW-1:0]       gidx;     // binary copy of grant, used to mux the owner
  logic [IDXW-1:0]       sel_idx;
  logic                  sel_found;
  logic [MAX_INPUTS-1:0] sel_oh;
  logic                  unused_oh;
  logic                  out_free;
  logic                  xfer;

  noc_rr_select #(.N(INPUTS), .IDXW(IDXW)) u_sel (
    .req   (in_valid),
    .ptr   (rr_ptr),
    .idx   (sel_idx),
    .found (sel_found)
  );

  assign sel_oh    = onehot(MAX_IDXW'(sel_idx));
  assign unused_oh = ^sel_oh;

  // Output stage can take a new flit if empty or draining this cycle.
  assign out_free = !out_valid || out_ready;
  assign in_ready = (state == ARB_BUSY && out_free) ? grant : '0;
  assign xfer     = (state == ARB_BUSY) && out_free && in_valid[gidx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ARB_IDLE;
      rr_ptr    <= '0;
      gidx      <= '0;
      grant     <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_flit  <= '0;
      out_last  <= 1'b0;
    end else if (state == ARB_IDLE) begin
      // Last flit of the previous packet may still be sitting in the stage.
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (sel_found) begin
        state <= ARB_BUSY;
        gidx  <= sel_idx;
        grant <= sel_oh[INPUTS-1:0];
        busy  <= 1'b1;
      end
    end else begin
      if (xfer) begin
        out_flit  <= in_flit[gidx];
        out_last  <= in_last[gidx];
        out_valid <= 1'b1;
        if (in_last[gidx]) begin
          state  <= ARB_IDLE;
          rr_ptr <= (gidx == IDXW'(INPUTS-1)) ? '0 : gidx + IDXW'(1);
          grant  <= '0;
          busy   <= 1'b0;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_noc_packet_arbiter.sv
// Randomized bench for noc_packet_arbiter (INPUTS=5) against a cycle-level
// behavioural model plus an in-order flit scoreboard.
module tb_noc_packet_arbiter;

  localparam int N = 5;
  localparam int W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0][W-1:0] in_flit = '0;
  logic [N-1:0]      in_last = '0;
  logic [N-1:0]      in_valid = '0;
  logic [N-1:0]      in_ready;
  logic [W-1:0]      out_flit;
  logic              out_last;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [N-1:0]      grant;
  logic              busy;

  noc_packet_arbiter #(.FLIT_WIDTH(W), .INPUTS(N)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_flit   (in_flit),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_flit  (out_flit),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Stimulus knobs
  logic [N-1:0] en;
  int p_req, p_go, p_ordy;

  // Requester state
  int        s_rem [N];
  logic [N-1:0] acc;
  int        seq;

  // Reference model state
  bit        m_busy;
  int        m_owner, m_ptr;
  bit        m_ov, m_ol;
  logic [W-1:0] m_of;
  logic [W-1:0] sb_q [$];

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_ov = 0; m_ol = 0; m_of = '0;
    sb_q.delete();
    acc = '0;
    for (int i = 0; i < N; i++) s_rem[i] = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (in_valid[i] && !acc[i]) continue;   // must hold while not accepted
      if (acc[i]) s_rem[i]--;
      in_valid[i] = 1'b0;
      if (s_rem[i] == 0 && en[i] && $urandom_range(99) < p_req)
        s_rem[i] = 1 + $urandom_range(3);
      if (s_rem[i] > 0 && $urandom_range(99) < p_go) begin
        seq++;
        in_flit[i]  = {8'(i), 24'(seq)};
        in_last[i]  = (s_rem[i] == 1);
        in_valid[i] = 1'b1;
      end
    end
    acc = '0;
    out_ready = ($urandom_range(99) < p_ordy);
  endtask

  task automatic check_and_advance();
    logic [N-1:0] eg, er;
    eg = '0; er = '0;
    if (m_busy) begin
      eg[m_owner] = 1'b1;
      if (!m_ov || out_ready) er[m_owner] = 1'b1;
    end
    chk("grant", 64'(grant), 64'(eg));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("in_ready", 64'(in_ready), 64'(er));
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    if (m_ov) begin
      chk("out_flit", 64'(out_flit), 64'(m_of));
      chk("out_last", 64'(out_last), 64'(m_ol));
    end
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) chk("sb_extra_flit", 64'(out_flit), 64'hDEAD);
      else chk("sb_order", 64'(out_flit), 64'(sb_q.pop_front()));
    end
    acc = in_valid & er;
    // next state
    if (!m_busy) begin
      if (m_ov && out_ready) m_ov = 0;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (in_valid[j]) begin
          m_busy = 1; m_owner = j;
          break;
        end
      end
    end else if (acc[m_owner]) begin
      m_ov = 1; m_of = in_flit[m_owner]; m_ol = in_last[m_owner];
      sb_q.push_back(in_flit[m_owner]);
      if (in_last[m_owner]) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
      end
    end else if (m_ov && out_ready) begin
      m_ov = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    drive();
    #1;
    check_and_advance();
  endtask

  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) step();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_grant"}, 64'(grant), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(0));
    chk({tag, "_out_flit"}, 64'(out_flit), 64'(0));
    chk({tag, "_out_last"}, 64'(out_last), 64'(0));
  endtask

  initial begin
    bit found;
    seq = 0;
    en = '0; p_req = 0; p_go = 0; p_ordy = 100;
    model_reset();
    // Reset state, with a request present that must not be acknowledged
    in_valid = 5'b00100;
    #3;
    check_idle_outputs("reset");
    in_valid = '0;
    @(negedge clk);
    rst = 1'b1;

    // Single source, no backpressure
    en = 5'b00010; p_req = 100; p_go = 100; p_ordy = 100;
    run(40);
    // All sources contend with continuous packets
    en = '1;
    run(120);
    // Random traffic with stalls and backpressure
    p_req = 40; p_go = 70; p_ordy = 60;
    run(1500);
    p_ordy = 15; p_go = 90;
    run(400);

    // Reset in the middle of a packet with the output stage loaded
    p_req = 100; p_go = 100; p_ordy = 30;
    found = 0;
    for (int c = 0; c < 500 && !found; c++) begin
      step();
      if (m_busy && m_ov) found = 1;
    end
    chk("mid_reset_reached", 64'(found), 64'(1));
    #1;
    rst = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    in_valid = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    // Arbitration restarts from pointer 0
    p_req = 50; p_go = 80; p_ordy = 70;
    run(400);

    // Drain remaining packets and make sure nothing was lost
    en = '0; p_go = 100; p_ordy = 100;
    run(80);
    chk("sb_drain", 64'(sb_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
